rv32_decode_queue: RTL and testbench



---
 rtl/rv32_decode_queue_if.sv | 32 +++
 rtl/rv32_decode_queue.sv | 65 ++++++
 tb/tb_rv32_decode_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rv32_decode_queue_if.sv
// rv32_decode_queue_if: fetch-side and decode-side handshake/data bundle for rv32_decode_queue.
interface rv32_decode_queue_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          flush_in;
    logic          valid_in;
    logic          ready_out;
    logic [31:0]   pc_in;
    logic [31:0]   instr_in;
    logic          branch_predicted_taken_in;
    logic          valid_out;
    logic          ready_in;
    logic [31:0]   pc_out;
    logic [31:0]   instr_out;
    logic          branch_predicted_taken_out;
    logic [4:0]    rs1_out;
    logic [4:0]    rs2_out;
    logic [4:0]    rd_out;
    logic [11:0]   csr_out;
    logic [CW-1:0] count_out;
    logic          empty_out;
    logic          full_out;
    modport slave (
        input  flush_in, valid_in, pc_in, instr_in, branch_predicted_taken_in, ready_in,
        output ready_out, valid_out, pc_out, instr_out, branch_predicted_taken_out,
               rs1_out, rs2_out, rd_out, csr_out, count_out, empty_out, full_out
    );
    modport master (
        output flush_in, valid_in, pc_in, instr_in, branch_predicted_taken_in, ready_in,
        input  ready_out, valid_out, pc_out, instr_out, branch_predicted_taken_out,
               rs1_out, rs2_out, rd_out, csr_out, count_out, empty_out, full_out
    );
endinterface

// File: rtl/rv32_decode_queue.sv
// rv32_decode_queue: DEPTH-entry fetch-to-decode FIFO with flush; RV32_DECODE_QUEUE_BYPASS_EN adds a zero-latency path through an empty queue.
module rv32_decode_queue #(parameter int DEPTH = 4) (
    input logic                clk,
    input logic                reset_n,
    rv32_decode_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [64:0]   mem_q [DEPTH];
    logic [64:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, byp, push, pop, wr_en, rd_en;
    logic [64:0]   head;

    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);
`ifdef RV32_DECODE_QUEUE_BYPASS_EN
    assign byp  = empty && !q.flush_in && q.valid_in;
    assign head = byp ? {q.pc_in, q.instr_in, q.branch_predicted_taken_in} : mem_q[rd_ptr_q];
`else
    assign byp  = 1'b0;
    assign head = mem_q[rd_ptr_q];
`endif
    assign q.valid_out = byp || (!empty && !q.flush_in);
    assign q.ready_out = !full;
    assign push  = q.valid_in && !full && !q.flush_in;
    assign pop   = q.valid_out && q.ready_in;
    // A bypassed entry consumed in the same cycle never touches storage
    assign wr_en = push && !(byp && pop);
    assign rd_en = pop && !byp;

    assign q.pc_out                     = q.valid_out ? head[64:33] : '0;
    assign q.instr_out                  = q.valid_out ? head[32:1] : '0;
    assign q.branch_predicted_taken_out = q.valid_out && head[0];
    assign q.rs1_out   = q.instr_out[19:15];
    assign q.rs2_out   = q.instr_out[24:20];
    assign q.rd_out    = q.instr_out[11:7];
    assign q.csr_out   = q.instr_out[31:20];
    assign q.count_out = count_q;
    assign q.empty_out = empty;
    assign q.full_out  = full;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = q.flush_in ? wr_ptr_q : rd_ptr_q + AW'(rd_en);
        count_d  = q.flush_in ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
        if (wr_en) mem_d[wr_ptr_q] = {q.pc_in, q.instr_in, q.branch_predicted_taken_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_rv32_decode_queue.sv
// tb_rv32_decode_queue: directed self-checking bench for rv32_decode_queue (DEPTH=4).
module tb_rv32_decode_queue;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    rv32_decode_queue_if #(.DEPTH(4)) q ();
    rv32_decode_queue #(.DEPTH(4)) dut (.clk(clk), .reset_n(reset_n), .q(q));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mq [$];
        logic [31:0] exp_pc;
        int pops;
        q.flush_in = 0; q.valid_in = 0; q.ready_in = 0;
        q.pc_in = 0; q.instr_in = 0; q.branch_predicted_taken_in = 0;
        reset_n = 0;
        #1;
        chk("rst_valid", 32'(q.valid_out), 0);
        chk("rst_ready", 32'(q.ready_out), 1);
        chk("rst_empty", 32'(q.empty_out), 1);
        chk("rst_full", 32'(q.full_out), 0);
        chk("rst_count", 32'(q.count_out), 0);
        tick; reset_n = 1; tick;

        // latency through an empty queue
        q.valid_in = 1; q.pc_in = 32'h200; q.instr_in = 32'h13; q.ready_in = 1;
        #1;
`ifdef RV32_DECODE_QUEUE_BYPASS_EN
        chk("byp_valid", 32'(q.valid_out), 1);
        chk("byp_pc", q.pc_out, 32'h200);
        tick; q.valid_in = 0; #1;
        chk("byp_count", 32'(q.count_out), 0);
`else
        chk("lat_valid0", 32'(q.valid_out), 0);
        chk("lat_pc0", q.pc_out, 0);
        tick; q.valid_in = 0; #1;
        chk("lat_valid1", 32'(q.valid_out), 1);
        chk("lat_pc1", q.pc_out, 32'h200);
        chk("lat_count1", 32'(q.count_out), 1);
        tick;
        chk("lat_count_after", 32'(q.count_out), 0);
`endif

        // fill to full with decode stalled
        q.ready_in = 0;
        for (int i = 0; i < 4; i++) begin
            q.valid_in = 1; q.pc_in = 32'h100 + 32'(4 * i); q.instr_in = 32'h1000 + 32'(i);
            q.branch_predicted_taken_in = i[0];
            tick;
        end
        chk("fill_full", 32'(q.full_out), 1);
        chk("fill_ready", 32'(q.ready_out), 0);
        chk("fill_count", 32'(q.count_out), 4);
        q.pc_in = 32'h110; q.instr_in = 32'h1004;
        tick;
        chk("fill_reject_count", 32'(q.count_out), 4);
        q.valid_in = 0; q.ready_in = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_pc", q.pc_out, 32'h100 + 32'(4 * i));
            chk("drain_instr", q.instr_out, 32'h1000 + 32'(i));
            chk("drain_bp", 32'(q.branch_predicted_taken_out), 32'(i % 2));
            tick;
            if (i == 0) chk("drain_ready_after_pop", 32'(q.ready_out), 1);
        end
        #1;
        chk("drain_empty", 32'(q.empty_out), 1);
        chk("drain_valid", 32'(q.valid_out), 0);
        chk("drain_pc_zero", q.pc_out, 0);

        // field extraction
        q.ready_in = 0; q.valid_in = 1; q.pc_in = 32'h500; q.instr_in = 32'h34202573;
        q.branch_predicted_taken_in = 0;
        tick; q.valid_in = 0; #1;
        chk("fld_csr", 32'(q.csr_out), 32'h342);
        chk("fld_rs1", 32'(q.rs1_out), 0);
        chk("fld_rd", 32'(q.rd_out), 10);
        chk("fld_rs2", 32'(q.rs2_out), 2);
        q.ready_in = 1; tick; q.ready_in = 0;

        // flush with two entries queued and a same-cycle offer
        for (int i = 0; i < 2; i++) begin
            q.valid_in = 1; q.pc_in = 32'h600 + 32'(4 * i); q.instr_in = 32'h2000 + 32'(i);
            tick;
        end
        chk("pre_flush_count", 32'(q.count_out), 2);
        q.flush_in = 1; q.valid_in = 1; q.pc_in = 32'h300; q.ready_in = 1;
        #1;
        chk("flush_valid", 32'(q.valid_out), 0);
        tick; q.flush_in = 0; q.valid_in = 0; #1;
        chk("flush_count", 32'(q.count_out), 0);
        chk("flush_empty", 32'(q.empty_out), 1);
        chk("flush_valid_next", 32'(q.valid_out), 0);
        tick;
        chk("flush_dropped", 32'(q.count_out), 0);

        // full-rate streaming across pointer wrap
        q.ready_in = 1; pops = 0;
        for (int k = 0; k < 13; k++) begin
            q.valid_in = k < 10; q.pc_in = 32'h400 + 32'(4 * k); q.instr_in = 32'(k);
            #1;
            if (q.valid_in && q.ready_out) mq.push_back(q.pc_in);
            if (q.valid_out && q.ready_in) begin
                exp_pc = mq.size() > 0 ? mq.pop_front() : 32'hdeadbeef;
                chk("wrap_order", q.pc_out, exp_pc);
                pops++;
            end
            chk("wrap_count_le1", 32'(q.count_out <= 1), 1);
            tick;
        end
        chk("wrap_pops", 32'(pops), 10);
        chk("wrap_empty", 32'(q.empty_out), 1);

        // asynchronous reset with three entries queued
        q.ready_in = 0;
        for (int i = 0; i < 3; i++) begin
            q.valid_in = 1; q.pc_in = 32'h700 + 32'(4 * i); q.instr_in = 32'h3000 + 32'(i);
            tick;
        end
        q.valid_in = 0;
        chk("pre_rst_count", 32'(q.count_out), 3);
        #3 reset_n = 0;
        #1;
        chk("arst_valid", 32'(q.valid_out), 0);
        chk("arst_count", 32'(q.count_out), 0);
        chk("arst_ready", 32'(q.ready_out), 1);
        chk("arst_pc", q.pc_out, 0);
        chk("arst_instr", q.instr_out, 0);
        chk("arst_empty", 32'(q.empty_out), 1);
        tick; reset_n = 1; tick;
        chk("post_rst_valid", 32'(q.valid_out), 0);
        chk("post_rst_count", 32'(q.count_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
